// File: rtl/acc_barrel_shifter.sv
// acc_barrel_shifter
//   Elastic two-stage barrel shifter for the accumulator-to-address path.
//   It widens an accumulator word to W_OUT bits, shifts it by a per-beat
//   amount in one of four modes, and flags set bits lost on logical left
//   shifts. Valid/ready handshakes on both sides allow backpressure.
//
// Ports
//   clk        clock, rising edge
//   clr        asynchronous active-high reset
//   in_valid   input beat present
//   in_ready   block can accept a beat this cycle
//   in_data    [W_IN-1:0] accumulator operand
//   in_sh      [W_SH-1:0] shift amount
//   in_mode    [1:0] 00 lsl, 01 lsr, 10 asr, 11 rotate left
//   out_valid  result present
//   out_ready  downstream accepts the result
//   out_data   [W_OUT-1:0] shifted result
//   out_ovf    left-shift overflow flag (mode 00 only)
module acc_barrel_shifter #(
  parameter int W_IN  = 19,
  parameter int W_OUT = 25,
  parameter int W_SH  = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  in_data,
  input  logic [W_SH-1:0]  in_sh,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] out_data,
  output logic             out_ovf
);

  // Number of conditional subtractions needed to bring any shift amount
  // below W_OUT for the rotate mode.
  localparam int ROT_STEPS = (2**W_SH) / W_OUT + 1;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

  // Logical left shift as a log2 cascade; stages of 2^i >= W_OUT clear.
  function automatic logic [W_OUT-1:0] shl(input logic [W_OUT-1:0] x,
                                           input logic [W_SH-1:0]  s);
    logic [W_OUT-1:0] r;
    r = x;
    for (int i = 0; i < W_SH; i++) begin
      if (s[i]) begin
        if ((2**i) >= W_OUT) r = '0;
        else                 r = r << (2**i);
      end
    end
    return r;
  endfunction

  // Right shift cascade; fill selects zero fill or sign fill.
  function automatic logic [W_OUT-1:0] shr(input logic [W_OUT-1:0] x,
                                           input logic [W_SH-1:0]  s,
                                           input logic             fill);
    logic [W_OUT-1:0] r;
    logic [W_OUT-1:0] ones;
    ones = '1;
    r    = x;
    for (int i = 0; i < W_SH; i++) begin
      if (s[i]) begin
        if ((2**i) >= W_OUT) r = {W_OUT{fill}};
        else                 r = (r >> (2**i)) | (fill ? ~(ones >> (2**i)) : '0);
      end
    end
    return r;
  endfunction

  // Reduce a shift amount modulo W_OUT by repeated compare/subtract.
  function automatic logic [W_SH-1:0] rot_amt(input logic [W_SH-1:0] s);
    logic [W_SH-1:0] r;
    r = s;
    for (int k = 0; k < ROT_STEPS; k++) begin
      if (int'(r) >= W_OUT) r = W_SH'(int'(r) - W_OUT);
    end
    return r;
  endfunction

  // Rotate left by an amount already reduced below W_OUT.
  function automatic logic [W_OUT-1:0] rotl(input logic [W_OUT-1:0] x,
                                            input logic [W_SH-1:0]  s);
    logic [W_OUT-1:0] r;
    r = x;
    for (int i = 0; i < W_SH; i++) begin
      if (s[i] && ((2**i) < W_OUT)) r = (r << (2**i)) | (r >> (W_OUT - 2**i));
    end
    return r;
  endfunction

  // Bits that leave the word on a left shift by s: the top s positions,
  // or the whole word once s reaches W_OUT.
  function automatic logic lsl_ovf(input logic [W_OUT-1:0] x,
                                   input logic [W_SH-1:0]  s);
    logic [W_OUT-1:0] keep;
    keep = shr('1, s, 1'b0);
    return |(x & ~keep);
  endfunction

  logic signed [W_IN-1:0]  in_signed;
  logic        [W_OUT-1:0] ext_in;

  logic                    vld_p1;
  logic        [W_OUT-1:0] data_p1;
  logic        [W_SH-1:0]  sh_p1;
  logic        [1:0]       mode_p1;

  logic                    vld_p2;
  logic        [W_OUT-1:0] data_p2;
  logic                    ovf_p2;

  logic        [W_OUT-1:0] res;
  logic                    res_ovf;
  logic                    ld_p1;
  logic                    ld_p2;

  // Stage 2 loads when empty or draining; stage 1 when empty or advancing.
  assign ld_p2    = !vld_p2 || out_ready;
  assign ld_p1    = !vld_p1 || ld_p2;
  assign in_ready = ld_p1;

  // Only the arithmetic mode sign-extends the operand.
  assign in_signed = in_data;
  assign ext_in    = (in_mode == MODE_ASR) ? W_OUT'(in_signed) : W_OUT'(in_data);

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (mode_p1)
      MODE_LSL: begin
        res     = shl(data_p1, sh_p1);
        res_ovf = lsl_ovf(data_p1, sh_p1);
      end
      MODE_LSR: res = shr(data_p1, sh_p1, 1'b0);
      MODE_ASR: res = shr(data_p1, sh_p1, data_p1[W_OUT-1]);
      default:  res = rotl(data_p1, rot_amt(sh_p1));
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sh_p1   <= '0;
      mode_p1 <= '0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      ovf_p2  <= 1'b0;
    end else begin
      // ---- stage 1: capture widened operand ----
      if (ld_p1) begin
        vld_p1 <= in_valid;
        if (in_valid) begin
          data_p1 <= ext_in;
          sh_p1   <= in_sh;
          mode_p1 <= in_mode;
        end
      end
      // ---- stage 2: shifted result ----
      if (ld_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          data_p2 <= res;
          ovf_p2  <= res_ovf;
        end
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_ovf   = ovf_p2;

endmodule

// File: tb/tb_acc_barrel_shifter.sv
// tb_acc_barrel_shifter
//   Directed and randomized bench for acc_barrel_shifter. A queue-based
//   reference model predicts each accepted beat from the shift rules using
//   plain 64-bit arithmetic; a negedge monitor retires results against it.
module tb_acc_barrel_shifter;

  localparam int W_IN  = 19;
  localparam int W_OUT = 25;
  localparam int W_SH  = 5;

  logic             clk = 1'b0;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [W_IN-1:0]  in_data;
  logic [W_SH-1:0]  in_sh;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W_OUT-1:0] out_data;
  logic             out_ovf;

  acc_barrel_shifter #(.W_IN(W_IN), .W_OUT(W_OUT), .W_SH(W_SH)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sh     (in_sh),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [W_OUT-1:0] d;
    logic             o;
  } exp_t;
  exp_t q[$];

  logic             held = 1'b0;
  logic [W_OUT-1:0] held_d;
  logic             held_o;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: widen, then apply the mode's rule on a 64-bit value.
  function automatic void model(input logic [W_IN-1:0] d, input int sh, input int mode,
                                output logic [W_OUT-1:0] o, output logic ovf);
    logic [63:0] ext, full, m;
    int r;
    m   = (64'd1 << W_OUT) - 64'd1;
    ext = 64'(d);
    if (mode == 2 && d[W_IN-1]) ext = ext | (m & ~((64'd1 << W_IN) - 64'd1));
    ovf = 1'b0;
    case (mode)
      0: begin
        full = ext << sh;
        o    = W_OUT'(full & m);
        ovf  = (full >> W_OUT) != 64'd0;
      end
      1: o = W_OUT'(ext >> sh);
      2: begin
        full = ext >> sh;
        if (ext[W_OUT-1]) full = full | (m & ~(m >> sh));
        o = W_OUT'(full);
      end
      default: begin
        r    = sh % W_OUT;
        full = (ext << r) | (ext >> (W_OUT - r));
        o    = W_OUT'(full & m);
      end
    endcase
  endfunction

  // Monitor: scoreboard retire, stall-hold check, and accept capture.
  always @(negedge clk) begin
    exp_t e;
    logic [W_OUT-1:0] md;
    logic mo;
    if (clr) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(held_d));
        chk("hold_ovf", 64'(out_ovf), 64'(held_o));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
        else begin
          e = q.pop_front();
          chk("sb_data", 64'(out_data), 64'(e.d));
          chk("sb_ovf", 64'(out_ovf), 64'(e.o));
        end
      end
      held   = out_valid && !out_ready;
      held_d = out_data;
      held_o = out_ovf;
      if (in_valid && in_ready) begin
        model(in_data, int'(in_sh), int'(in_mode), md, mo);
        e.d = md;
        e.o = mo;
        q.push_back(e);
      end
    end
  end

  // One beat into an empty pipeline with out_ready high; checks exact
  // 2-cycle latency and the literal expected result. Called at posedge+1.
  task automatic single(input string tag, input logic [W_IN-1:0] d, input int sh,
                        input int mode, input logic [W_OUT-1:0] ed, input logic eo);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_sh    = sh[W_SH-1:0];
    in_mode  = mode[1:0];
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, 64'(out_data), 64'(ed));
    chk({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W_IN-1:0] bd [4];
    logic [W_SH-1:0] bs [4];
    logic [1:0]      bm [4];
    int acc;
    int n;

    in_valid  = 1'b0;
    in_data   = '0;
    in_sh     = '0;
    in_mode   = '0;
    out_ready = 1'b1;
    clr       = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    clr = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed shift cases
    single("lsl6",   19'h7FFFF,  6, 0, 25'h1FFFFC0, 1'b0);
    single("lsl7",   19'h7FFFF,  7, 0, 25'h1FFFF80, 1'b1);
    single("lsl31",  19'h7FFFF, 31, 0, 25'h0000000, 1'b1);
    single("asr4",   19'h40000,  4, 2, 25'h1FFC000, 1'b0);
    single("asr30",  19'h40000, 30, 2, 25'h1FFFFFF, 1'b0);
    single("lsr4",   19'h40000,  4, 1, 25'h0004000, 1'b0);
    single("rol24",  19'h00001, 24, 3, 25'h1000000, 1'b0);
    single("rol25",  19'h00001, 25, 3, 25'h0000001, 1'b0);
    single("rol26",  19'h00001, 26, 3, 25'h0000002, 1'b0);
    single("lsl0",   19'h12345,  0, 0, 25'h0012345, 1'b0);

    // Backpressure: 6 stalled cycles offering 4 beats
    for (int i = 0; i < 4; i++) begin
      bd[i] = W_IN'($urandom);
      bs[i] = W_SH'($urandom);
      bm[i] = 2'($urandom);
    end
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (acc < 4) begin
        in_valid = 1'b1;
        in_data  = bd[acc];
        in_sh    = bs[acc];
        in_mode  = bm[acc];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (acc < 4) begin
        in_valid = 1'b1;
        in_data  = bd[acc];
        in_sh    = bs[acc];
        in_mode  = bm[acc];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_nogap", 64'(out_valid), 64'd1);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 64'(acc), 64'd4);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Reset with two beats in flight
    in_valid = 1'b1;
    in_data  = 19'h7FFFF;
    in_sh    = 5'd3;
    in_mode  = 2'b00;
    @(posedge clk);
    #1 in_data = 19'h55555;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 clr = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    chk("midrst_ovf", 64'(out_ovf), 64'd0);
    q.delete();
    @(negedge clk);
    @(posedge clk);
    #3 clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_nostale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    single("postrst", 19'h00F0F, 4, 1, 25'h00000F0, 1'b0);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 4) != 0);
      in_data   = W_IN'($urandom);
      in_sh     = W_SH'($urandom);
      in_mode   = 2'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("final_drain", 64'(q.size()), 64'd0);
    chk("final_idle", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
